// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder (with leaf cell adder_1)
//  Description : Bit-serial N-bit adder. Operands are captured on an
//                in_valid/in_ready handshake, summed one bit per clock LSB
//                first through a single 1-bit full-adder cell, and presented
//                on an out_valid/out_ready handshake.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                in_valid / in_ready   - operand handshake (a, b, c_in)
//                out_valid / out_ready - result handshake (sum, c_out[, ovf])
//  Options     : SERIAL_ADDER_OVF_EN   - when defined, adds output ovf
//                                        (signed overflow of the addition)
//  Revision    : 1.0 - initial release
// ============================================================================

// ---------------------------------------------------------------------------
//  adder_1 : 1-bit full adder
// ---------------------------------------------------------------------------
module adder_1 (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// ---------------------------------------------------------------------------
//  serial_adder : top level
// ---------------------------------------------------------------------------
module serial_adder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         c_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic         ovf
`endif
);

   // One extra bit so the counter can represent N without wrapping.
   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic            r_carry;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_sum;
   logic            r_cout;
   logic            r_in_ready;
   logic            r_out_valid;
`ifdef SERIAL_ADDER_OVF_EN
   logic            r_ovf;
`endif

   logic            w_s;
   logic            w_c;
   logic            w_last;

   // The only arithmetic element: operand LSBs plus the running carry.
   adder_1 u_fa (
      .i_a (r_a[0]),
      .i_b (r_b[0]),
      .i_c (r_carry),
      .o_s (w_s),
      .o_c (w_c)
   );

   assign w_last = (r_cnt == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_carry    <= c_in;
                  r_cnt      <= '0;
                  r_sum      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               for (int i = 0; i < N; i++) begin
                  if (r_cnt == CW'(i)) begin
                     r_sum[i] <= w_s;
                  end
               end
               r_carry <= w_c;
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               if (w_last) begin
                  r_cout      <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
                  // r_carry here is the carry into the MSB.
                  r_ovf       <= r_carry ^ w_c;
`endif
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign c_out     = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf       = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (N=8). Directed cases
//                plus randomized operands compared with an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic         c_in;
   logic [N-1:0] a;
   logic [N-1:0] b;
   wire          in_ready;
   wire          out_valid;
   wire          c_out;
   wire  [N-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
   wire          ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_adder #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction checked against plain arithmetic.
   task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                        input logic tc, input int hold, input bit noise);
      logic [N:0]   full;
      logic [N-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
      int           t;
      full     = {1'b0, ta} + {1'b0, tb_v} + {{N{1'b0}}, tc};
      exp_sum  = full[N-1:0];
      exp_cout = full[N];
      exp_ovf  = (ta[N-1] == tb_v[N-1]) && (exp_sum[N-1] != ta[N-1]);

      t = 0;
      while (!in_ready && t < 50) begin
         tick();
         t++;
      end
      check("in_ready_wait", {63'd0, in_ready}, 64'd1);

      a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
      tick();                                   // accept edge
      check("sum_cleared", {56'd0, sum}, 64'd0);
      check("busy_in_ready", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b0;

      for (int k = 1; k <= N; k++) begin
         if (noise) begin
            in_valid = 1'($urandom);
            a = N'($urandom);
            b = N'($urandom);
            c_in = 1'($urandom);
         end
         tick();
         check($sformatf("out_valid_edge%0d", k), {63'd0, out_valid},
               (k == N) ? 64'd1 : 64'd0);
      end
      in_valid = 1'b0;

      check("sum", {56'd0, sum}, {56'd0, exp_sum});
      check("c_out", {63'd0, c_out}, {63'd0, exp_cout});
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf", {63'd0, ovf}, {63'd0, exp_ovf});
`else
      if (exp_ovf) t = 0;                      // model value unused without ovf
`endif

      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         tick();
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_sum", {56'd0, sum}, {56'd0, exp_sum});
         check("hold_cout", {63'd0, c_out}, {63'd0, exp_cout});
      end

      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_in_ready", {63'd0, in_ready}, 64'd1);
      check("idle_out_valid", {63'd0, out_valid}, 64'd0);
      check("idle_sum_kept", {56'd0, sum}, {56'd0, exp_sum});
      check("idle_cout_kept", {63'd0, c_out}, {63'd0, exp_cout});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c_in = 1'b0;
      tick();
      tick();
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_sum", {56'd0, sum}, 64'd0);
      check("rst_cout", {63'd0, c_out}, 64'd0);
      rst = 1'b0;

      // First accept lands on the first edge after reset release.
      do_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'h7F, 8'h00, 1'b1, 0, 1'b0);
      do_op(8'hAA, 8'h55, 1'b1, 5, 1'b0);
      do_op(8'h12, 8'h34, 1'b0, 1, 1'b1);    // noise during RUN ignored

      // Reset mid-operation aborts with no result.
      a = 8'h12; b = 8'h34; c_in = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check("abort_sum", {56'd0, sum}, 64'd0);
      check("abort_in_ready", {63'd0, in_ready}, 64'd1);
      do_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         do_op(N'($urandom), N'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
